// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between IF (read-only) and MEM (load/store).
// MEM has fixed priority; a watchdog parks the block in ERR if the port never acks.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              port_req_o,
    output logic              port_we_o,
    output logic [ADDR_W-1:0] port_addr_o,
    output logic [DATA_W-1:0] port_wdata_o,
    input  logic              port_ack_i,
    input  logic [DATA_W-1:0] port_rdata_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_MEM,
        SERVE_IF,
        DONE,
        ERR
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            mem_any;
    logic            in_serve;
    logic            grant_mem;
    logic            grant_if;
    logic            wd_expire;
    logic            served_mem_q;
    logic [WD_W-1:0] wd_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        wd_expire = 1'b0;
        mem_any   = mem_rd_i | mem_wr_i;
        in_serve  = (state_q == SERVE_MEM) || (state_q == SERVE_IF);
        case (state_q)
            IDLE: begin
                if (start_i && mem_any) begin
                    grant_mem = 1'b1;
                    state_d   = SERVE_MEM;
                end else if (start_i && if_req_i) begin
                    grant_if = 1'b1;
                    state_d  = SERVE_IF;
                end
            end
            SERVE_MEM, SERVE_IF: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (port_ack_i) begin
                    state_d = DONE;
                end else if (wd_cnt_q == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_d   = ERR;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            port_req_o   <= 1'b0;
            port_we_o    <= 1'b0;
            port_addr_o  <= '0;
            port_wdata_o <= '0;
            if_rdata_o   <= '0;
            mem_rdata_o  <= '0;
            served_mem_q <= 1'b0;
            wd_cnt_q     <= '0;
            err_o        <= 1'b0;
        end else if (grant_mem || grant_if) begin
            port_req_o   <= 1'b1;
            port_we_o    <= grant_mem & mem_wr_i;
            port_addr_o  <= grant_mem ? mem_addr_i : if_addr_i;
            port_wdata_o <= grant_mem ? mem_wdata_i : '0;
            served_mem_q <= grant_mem;
            wd_cnt_q     <= '0;
        end else if (in_serve) begin
            if (port_ack_i) begin
                port_req_o <= 1'b0;
                wd_cnt_q   <= '0;
                if (!served_mem_q) begin
                    if_rdata_o <= port_rdata_i;
                end else if (!port_we_o) begin
                    mem_rdata_o <= port_rdata_i;
                end
            end else if (wd_expire) begin
                port_req_o <= 1'b0;
                err_o      <= 1'b1;
            end else begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        if_ready_o  = (state_q == DONE) && !served_mem_q;
        mem_ready_o = (state_q == DONE) && served_mem_q;
        stall_o     = (state_q == ERR)
                    | (if_req_i & ~if_ready_o)
                    | ((mem_rd_i | mem_wr_i) & ~mem_ready_o);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized transactions against mem_port_arbiter; the bench plays
// both requesters and the memory port and predicts results at transaction level.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          if_ready_o;
    logic          mem_rd_i;
    logic          mem_wr_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic [DW-1:0] mem_rdata_o;
    logic          mem_ready_o;
    logic          port_req_o;
    logic          port_we_o;
    logic [AW-1:0] port_addr_o;
    logic [DW-1:0] port_wdata_o;
    logic          port_ack_i;
    logic [DW-1:0] port_rdata_i;
    logic          stall_o;
    logic          err_o;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_ready = 0;
    bit          both_rw = 1'b0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_mem_rdata = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
        .port_req_o(port_req_o), .port_we_o(port_we_o), .port_addr_o(port_addr_o),
        .port_wdata_o(port_wdata_o), .port_ack_i(port_ack_i), .port_rdata_i(port_rdata_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic raise(input bit is_mem, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (is_mem) begin
            mem_rd_i    = wr ? both_rw : 1'b1;
            mem_wr_i    = wr;
            mem_addr_i  = addr;
            mem_wdata_i = wdata;
        end else begin
            if_req_i  = 1'b1;
            if_addr_i = addr;
        end
    endtask

    task automatic drop(input bit is_mem);
        if (is_mem) begin
            mem_rd_i = 1'b0;
            mem_wr_i = 1'b0;
        end else begin
            if_req_i = 1'b0;
        end
    endtask

    // Entered in the cycle whose closing edge should grant this requester.
    task automatic serve(input bit is_mem, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int d, input bit other_wait);
        int t0;
        t0 = cyc;
        tick();
        chk1("grant_req", port_req_o, 1'b1);
        chk1("grant_we", port_we_o, is_mem & wr);
        chk32("grant_addr", port_addr_o, addr);
        if (is_mem && wr) chk32("grant_wdata", port_wdata_o, wdata);
        chk1("grant_stall", stall_o, 1'b1);
        for (int i = 0; i < d; i++) begin
            tick();
            chk1("wait_req", port_req_o, 1'b1);
            chk32("wait_addr", port_addr_o, addr);
            chk1("wait_rdy", if_ready_o | mem_ready_o, 1'b0);
        end
        port_ack_i   = 1'b1;
        port_rdata_i = rdata;
        tick();
        port_ack_i   = 1'b0;
        port_rdata_i = $urandom;
        if (!is_mem) exp_if_rdata = rdata;
        else if (!wr) exp_mem_rdata = rdata;
        chk1("done_if_rdy", if_ready_o, !is_mem);
        chk1("done_mem_rdy", mem_ready_o, is_mem);
        chk32("done_if_rdata", if_rdata_o, exp_if_rdata);
        chk32("done_mem_rdata", mem_rdata_o, exp_mem_rdata);
        chk1("done_req", port_req_o, 1'b0);
        chk1("done_stall", stall_o, other_wait);
        chk32("latency", 32'(cyc - t0), 32'(2 + d));
        last_ready = cyc;
        tick();
        drop(is_mem);
        #1;
        chk1("idle_rdy", if_ready_o | mem_ready_o, 1'b0);
        chk1("idle_req", port_req_o, 1'b0);
        chk1("idle_stall", stall_o, other_wait);
    endtask

    task automatic pre(input int hold, input bit idle_ack);
        tick();
        if (idle_ack) begin
            port_ack_i   = 1'b1;
            port_rdata_i = $urandom;
            tick();
            port_ack_i = 1'b0;
            chk1("stray_ack_rdy", if_ready_o | mem_ready_o, 1'b0);
            chk1("stray_ack_req", port_req_o, 1'b0);
        end
        start_i = (hold == 0);
    endtask

    task automatic hold_off(input int hold);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk1("nostart_req", port_req_o, 1'b0);
            chk1("nostart_stall", stall_o, 1'b1);
        end
        start_i = 1'b1;
    endtask

    task automatic txn(input bit is_mem, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int d, input int hold, input bit idle_ack);
        pre(hold, idle_ack);
        raise(is_mem, wr, addr, wdata);
        #1;
        chk1("req_stall", stall_o, 1'b1);
        hold_off(hold);
        serve(is_mem, wr, addr, wdata, rdata, d, 1'b0);
    endtask

    task automatic pair(input bit wr, input logic [31:0] if_addr, input logic [31:0] mem_addr,
                        input logic [31:0] wdata, input logic [31:0] r1, input logic [31:0] r2,
                        input int d1, input int d2, input int hold);
        pre(hold, 1'b0);
        raise(1'b0, 1'b0, if_addr, '0);
        raise(1'b1, wr, mem_addr, wdata);
        #1;
        chk1("pair_stall", stall_o, 1'b1);
        hold_off(hold);
        serve(1'b1, wr, mem_addr, wdata, r1, d1, 1'b1);
        serve(1'b0, 1'b0, if_addr, '0, r2, d2, 1'b0);
    endtask

    initial begin
        int r1;
        int kind;
        rst_i        = 1'b0;
        start_i      = 1'b0;
        if_req_i     = 1'b0;
        if_addr_i    = '0;
        mem_rd_i     = 1'b0;
        mem_wr_i     = 1'b0;
        mem_addr_i   = '0;
        mem_wdata_i  = '0;
        port_ack_i   = 1'b0;
        port_rdata_i = '0;

        #12;
        chk1("rst_req", port_req_o, 1'b0);
        chk1("rst_we", port_we_o, 1'b0);
        chk32("rst_addr", port_addr_o, 32'h0);
        chk1("rst_err", err_o, 1'b0);
        chk1("rst_rdy", if_ready_o | mem_ready_o, 1'b0);
        chk32("rst_if_rdata", if_rdata_o, 32'h0);
        chk32("rst_mem_rdata", mem_rdata_o, 32'h0);
        chk1("rst_stall", stall_o, 1'b0);
        #5 rst_i = 1'b1;
        start_i = 1'b1;

        // Basic IF fetch, ack on the second port_req cycle
        txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h8C01_0004, 1, 0, 1'b0);
        // Simultaneous IF and MEM: MEM goes first
        pair(1'b0, 32'h0000_0020, 32'h0000_0100, 32'h0, 32'hAAAA_0001, 32'h2002_0003, 0, 0, 0);
        // Store with immediate ack leaves load data untouched
        txn(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1234_5678, 0, 0, 1'b0);
        // Back-to-back fetches
        txn(1'b0, 1'b0, 32'h0, 32'h0, 32'h1111_0000, 0, 0, 1'b0);
        r1 = last_ready;
        txn(1'b0, 1'b0, 32'h4, 32'h0, 32'h1111_0004, 0, 0, 1'b0);
        chk32("b2b_space1", 32'(last_ready - r1), 32'd4);
        r1 = last_ready;
        txn(1'b0, 1'b0, 32'h8, 32'h0, 32'h1111_0008, 0, 0, 1'b0);
        chk32("b2b_space2", 32'(last_ready - r1), 32'd4);

        for (int n = 0; n < 40; n++) begin
            int d1;
            int d2;
            int hold;
            kind    = int'($urandom_range(3, 0));
            d1      = int'($urandom_range(TO - 1, 0));
            d2      = int'($urandom_range(TO - 1, 0));
            hold    = ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            both_rw = 1'($urandom_range(1, 0));
            case (kind)
                0: txn(1'b0, 1'b0, $urandom, $urandom, $urandom, d1, hold, 1'($urandom_range(1, 0)));
                1: txn(1'b1, 1'b0, $urandom, $urandom, $urandom, d1, hold, 1'($urandom_range(1, 0)));
                2: txn(1'b1, 1'b1, $urandom, $urandom, $urandom, d1, hold, 1'($urandom_range(1, 0)));
                default: pair(1'($urandom_range(1, 0)), $urandom, $urandom, $urandom,
                              $urandom, $urandom, d1, d2, hold);
            endcase
        end
        both_rw = 1'b0;

        // Port never acks: request held exactly TO cycles, then sticky error
        tick();
        raise(1'b0, 1'b0, 32'h0000_0080, '0);
        for (int i = 0; i < int'(TO); i++) begin
            tick();
            chk1("to_req_high", port_req_o, 1'b1);
        end
        tick();
        chk1("to_req_drop", port_req_o, 1'b0);
        chk1("to_err", err_o, 1'b1);
        chk1("to_stall", stall_o, 1'b1);
        chk1("to_rdy", if_ready_o, 1'b0);
        port_ack_i = 1'b1;
        tick();
        port_ack_i = 1'b0;
        chk1("late_ack_rdy", if_ready_o | mem_ready_o, 1'b0);
        chk1("late_ack_err", err_o, 1'b1);
        drop(1'b0);
        raise(1'b1, 1'b0, 32'h0000_0300, '0);
        tick();
        tick();
        chk1("err_no_grant", port_req_o, 1'b0);
        chk1("err_no_rdy", mem_ready_o, 1'b0);
        drop(1'b1);
        #1;
        chk1("err_stall_forced", stall_o, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        exp_if_rdata  = '0;
        exp_mem_rdata = '0;
        chk1("err_rst_err", err_o, 1'b0);
        chk1("err_rst_stall", stall_o, 1'b0);
        chk32("err_rst_if_rdata", if_rdata_o, exp_if_rdata);
        #2 rst_i = 1'b1;

        // Async reset in the middle of an IF transaction
        tick();
        raise(1'b0, 1'b0, 32'h0000_0200, '0);
        tick();
        chk1("mid_req", port_req_o, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        chk1("mid_rst_req", port_req_o, 1'b0);
        chk1("mid_rst_rdy", if_ready_o, 1'b0);
        chk1("mid_rst_err", err_o, 1'b0);
        start_i = 1'b0;
        #2 rst_i = 1'b1;
        hold_off(3);
        serve(1'b0, 1'b0, 32'h0000_0200, '0, 32'h5A5A_0200, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
